// File: rtl/data_stream_arb_pkg.sv
// data_stream_arb_pkg: shared FSM state type and round-robin pick function for stream arbiters
package data_stream_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  localparam int MAX_SRC = 32;
  localparam int SRC_W = $clog2(MAX_SRC);
  function automatic logic [MAX_SRC-1:0] rr_next(input logic [MAX_SRC-1:0] req, input int last, input int n);
    logic [MAX_SRC-1:0] pick;
    int idx;
    pick = '0;
    for (int k = MAX_SRC; k >= 1; k--) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[SRC_W-1:0]]) begin
          pick = '0;
          pick[idx[SRC_W-1:0]] = 1'b1;
        end
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: picks the first requester cyclically after last_grant
module rr_priority_picker
  import data_stream_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  localparam int IW = $clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [IW-1:0]          last_grant,
  output logic [NUM_SOURCES-1:0] pick_onehot,
  output logic [IW-1:0]          pick_idx,
  output logic                   any_req
);
  logic [MAX_SRC-1:0] pick_w;
  assign pick_w = rr_next(MAX_SRC'(req), int'(last_grant), NUM_SOURCES);
  assign pick_onehot = pick_w[NUM_SOURCES-1:0];
  assign any_req = |pick_w;
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_SOURCES; i++) pick_idx = pick_onehot[i] ? IW'(i) : pick_idx;
  end
endmodule

// File: rtl/data_stream_rr_arbiter.sv
// data_stream_rr_arbiter: burst-limited round-robin sharing of one registered ready/valid stream
module data_stream_rr_arbiter
  import data_stream_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST = 8,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IW = $clog2(NUM_SOURCES),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SOURCES*STRB_WIDTH-1:0] s_strb,
  input  logic [NUM_SOURCES-1:0]            s_valid,
  output logic [NUM_SOURCES-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic [STRB_WIDTH-1:0]             m_strb,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [IW-1:0]                     m_src_id,
  output logic [NUM_SOURCES-1:0]            grant
);
  arb_state_t state, next_state;
  logic [IW-1:0] last_grant, pick_idx;
  logic [NUM_SOURCES-1:0] pick_onehot;
  logic any_req, out_free, g_valid, accept, rel;
  logic [CW-1:0] beat_cnt;
  rr_priority_picker #(.NUM_SOURCES(NUM_SOURCES)) u_picker (
    .req(s_valid),
    .last_grant(last_grant),
    .pick_onehot(pick_onehot),
    .pick_idx(pick_idx),
    .any_req(any_req)
  );
  always_comb begin
    out_free = !m_valid || m_ready;
    s_ready = (state == LOCKED && out_free) ? grant : '0;
    g_valid = |(s_valid & grant);
    accept = |(s_valid & s_ready);
    rel = state == LOCKED && (!g_valid || (accept && beat_cnt == CW'(MAX_BURST - 1)));
    next_state = state == IDLE ? (any_req ? LOCKED : IDLE) : (rel ? IDLE : LOCKED);
  end
  // last_grant doubles as the granted index while LOCKED
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(NUM_SOURCES - 1);
      beat_cnt <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_strb <= '0;
      m_src_id <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        grant <= any_req ? pick_onehot : '0;
        if (any_req) last_grant <= pick_idx;
      end else if (rel) grant <= '0;
      beat_cnt <= (state == IDLE || rel) ? '0 : accept ? beat_cnt + 1'b1 : beat_cnt;
      if (accept) begin
        m_data <= s_data[last_grant*DATA_WIDTH +: DATA_WIDTH];
        m_strb <= s_strb[last_grant*STRB_WIDTH +: STRB_WIDTH];
        m_src_id <= last_grant;
        m_valid <= 1'b1;
      end else if (m_ready) m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_data_stream_rr_arbiter.sv
// tb_data_stream_rr_arbiter: directed-vector bench comparing output beats against hand-derived timelines
module tb_data_stream_rr_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 2;
  typedef struct packed {
    logic [7:0]    cyc;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } beat_t;
  logic clk = 1'b0;
  logic rst, m_ready, sel;
  logic [NS*DW-1:0] s_data;
  logic [NS*SW-1:0] s_strb;
  logic [NS-1:0] s_valid;
  logic [NS-1:0] s_ready_a, s_ready_b, grant_a, grant_b, s_ready_x, grant_x;
  logic [DW-1:0] m_data_a, m_data_b, m_data_x;
  logic [SW-1:0] m_strb_a, m_strb_b, m_strb_x;
  logic m_valid_a, m_valid_b, m_valid_x;
  logic [IW-1:0] m_src_id_a, m_src_id_b, m_src_id_x;
  int errors = 0;
  int checks = 0;
  int seq [NS];
  beat_t got_q[$], exp_q[$];
  logic [NS-1:0] gh [64];
  logic [NS-1:0] sr [64];
  logic mv [64];
  logic [DW-1:0] md [64];
  always #5 clk = ~clk;
  data_stream_rr_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW), .MAX_BURST(8)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid), .s_ready(s_ready_a),
    .m_data(m_data_a), .m_strb(m_strb_a), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_src_id(m_src_id_a), .grant(grant_a)
  );
  data_stream_rr_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid), .s_ready(s_ready_b),
    .m_data(m_data_b), .m_strb(m_strb_b), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_src_id(m_src_id_b), .grant(grant_b)
  );
  assign s_ready_x = sel ? s_ready_b : s_ready_a;
  assign grant_x = sel ? grant_b : grant_a;
  assign m_data_x = sel ? m_data_b : m_data_a;
  assign m_strb_x = sel ? m_strb_b : m_strb_a;
  assign m_valid_x = sel ? m_valid_b : m_valid_a;
  assign m_src_id_x = sel ? m_src_id_b : m_src_id_a;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      s_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
      s_strb[i*SW +: SW] = SW'(seq[i] + i + 1);
    end
  endtask
  task automatic expect_beat(input int c, input int id, input int k);
    exp_q.push_back('{8'(c), IW'(id), {8'(id), 24'(k)}, SW'(k + id + 1)});
  endtask
  task automatic vec(input int test, input int c, output logic [NS-1:0] v, output logic r, output logic rs);
    v = '0;
    r = 1'b1;
    rs = 1'b0;
    case (test)
      1: v = 4'b1111;
      2: v = c == 0 ? 4'b0100 : c <= 3 ? 4'b0101 : c < 12 ? 4'b0001 : 4'b0101;
      3: begin
        v = 4'b0010;
        r = !(c >= 4 && c <= 8);
      end
      4: v = 4'b1010;
      5: begin
        v = c < 4 ? 4'b0010 : 4'b0011;
        rs = c == 4;
      end
      default: v = '0;
    endcase
  endtask
  task automatic run(input int test, input int n, input logic which);
    logic [NS-1:0] v, acc;
    logic r, rs;
    sel = which;
    rst = 1'b1;
    s_valid = '0;
    m_ready = 1'b1;
    for (int i = 0; i < NS; i++) seq[i] = 0;
    drive();
    got_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("t%0d_rst_m_valid", test), 64'(m_valid_x), 0);
    check($sformatf("t%0d_rst_m_data", test), 64'(m_data_x), 0);
    check($sformatf("t%0d_rst_m_strb_id", test), 64'({m_strb_x, m_src_id_x}), 0);
    check($sformatf("t%0d_rst_grant_ready", test), 64'({grant_x, s_ready_x}), 0);
    for (int c = 0; c < n; c++) begin
      vec(test, c, v, r, rs);
      s_valid = v;
      m_ready = r;
      rst = rs;
      #1;
      gh[c] = grant_x;
      sr[c] = s_ready_x;
      mv[c] = m_valid_x;
      md[c] = m_data_x;
      check($sformatf("t%0d_ready_onehot_c%0d", test, c), 64'($countones(s_ready_x) > 1), 0);
      acc = s_valid & s_ready_x;
      if (!rs && m_valid_x && m_ready) got_q.push_back('{8'(c), m_src_id_x, m_data_x, m_strb_x});
      @(posedge clk);
      #1;
      if (!rs) for (int i = 0; i < NS; i++) if (acc[i]) seq[i]++;
      drive();
    end
    rst = 1'b0;
  endtask
  task automatic compare(input int test);
    check($sformatf("t%0d_beat_count", test), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("t%0d_beat%0d{cyc,id,data,strb}", test, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask
  initial begin
    run(1, 46, 1'b0);
    for (int b = 0; b < 40; b++) expect_beat(2 + b + b / 8, (b / 8) % 4, (b / 32) * 8 + b % 8);
    compare(1);
    check("t1_grant_c1", 64'(gh[1]), 64'(4'b0001));
    check("t1_bubble_grant_c9", 64'(gh[9]), 0);
    check("t1_grant_c10", 64'(gh[10]), 64'(4'b0010));
    run(2, 18, 1'b0);
    for (int k = 0; k < 3; k++) expect_beat(2 + k, 2, k);
    for (int k = 0; k < 8; k++) expect_beat(7 + k, 0, k);
    expect_beat(16, 2, 3);
    expect_beat(17, 2, 4);
    compare(2);
    check("t2_grant_c4", 64'(gh[4]), 64'(4'b0100));
    check("t2_gap_grant_c5", 64'(gh[5]), 0);
    check("t2_grant_c6", 64'(gh[6]), 64'(4'b0001));
    run(3, 17, 1'b0);
    expect_beat(2, 1, 0);
    expect_beat(3, 1, 1);
    for (int k = 2; k < 8; k++) expect_beat(7 + k, 1, k);
    expect_beat(16, 1, 8);
    compare(3);
    for (int c = 4; c <= 8; c++) begin
      check($sformatf("t3_stall_s_ready_c%0d", c), 64'(sr[c]), 0);
      check($sformatf("t3_stall_m_data_c%0d", c), 64'({mv[c], md[c]}), 64'({1'b1, 8'd1, 24'd2}));
    end
    check("t3_release_grant_c14", 64'(gh[14]), 0);
    check("t3_regrant_c15", 64'(gh[15]), 64'(4'b0010));
    run(4, 10, 1'b1);
    expect_beat(2, 1, 0);
    expect_beat(4, 3, 0);
    expect_beat(6, 1, 1);
    expect_beat(8, 3, 1);
    compare(4);
    check("t4_grant_c1", 64'(gh[1]), 64'(4'b0010));
    check("t4_grant_c2", 64'(gh[2]), 0);
    run(5, 8, 1'b0);
    expect_beat(2, 1, 0);
    expect_beat(3, 1, 1);
    expect_beat(7, 0, 0);
    compare(5);
    check("t5_after_rst_m_valid", 64'(mv[5]), 0);
    check("t5_after_rst_grant", 64'(gh[5]), 0);
    check("t5_first_priority", 64'(gh[6]), 64'(4'b0001));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
